// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: default capture sizes and the capture FSM state type
package adc_cap_pkg;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_ADDR_W = 10;
  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} cap_state_t;
endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port sample buffer, one write port and a registered read port
module capture_ram
  import adc_cap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  always_ff @(posedge clk) rd <= rst ? '0 : mem[ra];
endmodule

// File: rtl/adc_trig_capture.sv
// adc_trig_capture: edge-triggered ADC capture buffer with pre-trigger history (ADC_TRIG_AUTO_EN adds a timeout auto-trigger)
module adc_trig_capture
  import adc_cap_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_pos,
  output logic              trig_auto
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};
  cap_state_t state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0] cnt, cnt_nx, post_len;
  logic [DATA_W-1:0] prev;
  logic prev_ok, force_pend, hit_edge, hit_man, hit_auto, hit;
  assign busy = state inside {PRE, WAIT_TRIG, POST};
  assign done = state == DONE;
  assign cnt_nx = cnt + ONE;
  assign post_len = DEPTH - {1'b0, pre_len};
  assign hit_edge = prev_ok && (trig_edge ? prev >= trig_level && adc_data < trig_level
                                          : prev < trig_level && adc_data >= trig_level);
  assign hit_man = force_trig || force_pend;
  assign hit = hit_edge || hit_man || hit_auto;
`ifdef ADC_TRIG_AUTO_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 2);
  logic [TW-1:0] tcnt;
  assign hit_auto = tcnt == TW'(AUTO_TIMEOUT);
  always_ff @(posedge clk_in)
    if (rst || state != WAIT_TRIG) tcnt <= '0;
    else if (adc_valid && !hit) tcnt <= tcnt + TW'(1);
`else
  assign hit_auto = 1'b0;
`endif
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      cnt        <= '0;
      prev       <= '0;
      prev_ok    <= 1'b0;
      force_pend <= 1'b0;
      trig_pos   <= '0;
      trig_auto  <= 1'b0;
    end else if (!busy) begin
      if (arm) begin
        state      <= pre_len == '0 ? WAIT_TRIG : PRE;
        wptr       <= '0;
        cnt        <= '0;
        prev_ok    <= 1'b0;
        force_pend <= 1'b0;
        trig_auto  <= 1'b0;
      end
    end else if (adc_valid) begin
      wptr    <= wptr + ADDR_W'(1);
      prev    <= adc_data;
      prev_ok <= 1'b1;
      if (state == PRE) begin
        cnt <= cnt_nx;
        if (cnt_nx == {1'b0, pre_len}) state <= WAIT_TRIG;
      end else if (state == WAIT_TRIG) begin
        if (hit) begin
          trig_pos   <= wptr;
          trig_auto  <= !(hit_edge || hit_man);
          force_pend <= 1'b0;
          cnt        <= ONE;
          state      <= post_len == ONE ? DONE : POST;
        end
      end else begin
        cnt <= cnt_nx;
        if (cnt_nx == post_len) state <= DONE;
      end
    end else if (state == WAIT_TRIG && force_trig) begin
      force_pend <= 1'b1;
    end
  end
  capture_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk_in),
    .rst(rst),
    .we(busy && adc_valid),
    .wa(wptr),
    .wd(adc_data),
    .ra(trig_pos - pre_len + rd_addr),
    .rd(rd_data)
  );
endmodule

// File: tb/tb_adc_trig_capture.sv
// tb_adc_trig_capture: randomized capture scenarios checked against a sample-stream model
module tb_adc_trig_capture;
  localparam int DW = 12;
  localparam int AW = 10;
  localparam int DEPTH = 1024;
  localparam int AT = 100;
`ifdef ADC_TRIG_AUTO_EN
  localparam bit AUTO_ON = 1'b1;
`else
  localparam bit AUTO_ON = 1'b0;
`endif
  logic clk_in = 1'b0;
  logic rst, adc_valid, arm, force_trig, trig_edge, busy, done, trig_auto;
  logic [DW-1:0] adc_data, trig_level, rd_data;
  logic [AW-1:0] pre_len, rd_addr, trig_pos;
  int checks = 0;
  int errors = 0;
  int q[$];
  always #5 clk_in = ~clk_in;
  adc_trig_capture #(.DATA_W(DW), .ADDR_W(AW), .AUTO_TIMEOUT(AT)) dut (
    .clk_in(clk_in), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid), .arm(arm),
    .force_trig(force_trig), .trig_level(trig_level), .trig_edge(trig_edge), .pre_len(pre_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .trig_pos(trig_pos),
    .trig_auto(trig_auto)
  );
  function automatic int pat(int mode, int k);
    return mode == 0 ? k % 4096 : mode == 2 ? 50 : mode == 3 ? ((k % 50 < 25) ? 3000 : 10)
                     : int'($urandom_range(4095));
  endfunction
  task automatic read_at(input int a);
    rd_addr = AW'(a);
    @(negedge clk_in);
  endtask
  task automatic capture(input int mode, input int lvl, input bit edg, input int pl,
                         input bit use_force, input bit arm_mid, input int max_n,
                         output bit got_done, output int trig, output bit auto_exp);
    int force_idx, k, idx;
    bit ev, av;
    logic [DW-1:0] e;
    force_idx = -1;
    trig = -1;
    auto_exp = 1'b0;
    got_done = 1'b0;
    q.delete();
    trig_level = DW'(lvl);
    trig_edge = edg;
    pre_len = AW'(pl);
    arm = 1'b1;
    force_trig = 1'b1;
    adc_valid = 1'b1;
    adc_data = 12'd4095;
    @(negedge clk_in);
    arm = 1'b0;
    force_trig = 1'b0;
    adc_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL arm_state busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    while (q.size() < max_n) begin
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      arm = arm_mid && trig >= 0 && q.size() == trig + 10;
      force_trig = 1'b0;
      if (use_force && force_idx < 0 && trig < 0 && q.size() >= pl) begin
        force_trig = 1'b1;
        force_idx = q.size();
        adc_valid = 1'b0;
      end else begin
        adc_valid = $urandom_range(3) != 0;
      end
      adc_data = adc_valid ? DW'(pat(mode, q.size())) : DW'($urandom_range(4095));
      if (adc_valid) begin
        q.push_back(int'(adc_data));
        k = q.size() - 1;
        if (trig < 0 && k >= pl) begin
          ev = k >= 1 && (edg ? (q[k-1] >= lvl && q[k] < lvl) : (q[k-1] < lvl && q[k] >= lvl));
          av = AUTO_ON && (k - pl >= AT);
          if (ev || force_idx >= 0 || av) begin
            trig = k;
            auto_exp = !(ev || force_idx >= 0);
          end
        end
      end
      @(negedge clk_in);
    end
    adc_valid = 1'b0;
    arm = 1'b0;
    force_trig = 1'b0;
    if (!got_done) got_done = done === 1'b1;
    if (got_done) begin
      checks++;
      if (q.size() != trig + DEPTH - pl || trig < 0) begin
        errors++;
        $display("FAIL sample_count got %0d samples at done, expected %0d (trigger %0d)", q.size(), trig + DEPTH - pl, trig);
      end
      checks++;
      if (trig_pos !== AW'(trig)) begin
        errors++;
        $display("FAIL trig_pos got %0d expected %0d", trig_pos, trig % DEPTH);
      end
      checks++;
      if (trig_auto !== auto_exp || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_flags trig_auto=%b busy=%b expected trig_auto=%b busy=0", trig_auto, busy, auto_exp);
      end
      for (int i = 0; i < DEPTH; i++) begin
        read_at(i);
        idx = trig - pl + i;
        e = (trig >= 0 && idx >= 0 && idx < q.size()) ? DW'(q[idx]) : 'x;
        checks++;
        if (rd_data !== e) begin
          errors++;
          $display("FAIL buffer rd_addr=%0d got %0d expected %0d", i, rd_data, e);
        end
      end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    adc_valid = 1'b0;
    adc_data = '0;
    arm = 1'b0;
    force_trig = 1'b0;
    trig_level = '0;
    trig_edge = 1'b0;
    pre_len = '0;
    rd_addr = '0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || trig_pos !== '0 || trig_auto !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b trig_pos=%0d trig_auto=%b rd_data=%0d expected all 0", busy, done, trig_pos, trig_auto, rd_data);
    end
    rst = 1'b0;
    @(negedge clk_in);
  endtask
  task automatic test_ramp_rising;
    bit g, a;
    int t;
    capture(0, 2000, 1'b0, 256, 1'b0, 1'b0, 8000, g, t, a);
    checks++;
    if (!g || trig_pos !== 10'd976) begin
      errors++;
      $display("FAIL ramp_rise done=%b trig_pos=%0d expected done=1 trig_pos=976", g, trig_pos);
    end
    read_at(256);
    checks++;
    if (rd_data !== 12'd2000) begin
      errors++;
      $display("FAIL ramp_rise_256 got %0d expected 2000", rd_data);
    end
    read_at(0);
    checks++;
    if (rd_data !== 12'd1744) begin
      errors++;
      $display("FAIL ramp_rise_0 got %0d expected 1744", rd_data);
    end
  endtask
  task automatic test_ramp_falling;
    bit g, a;
    int t;
    capture(0, 100, 1'b1, 256, 1'b0, 1'b0, 8000, g, t, a);
    read_at(256);
    checks++;
    if (!g || rd_data !== 12'd0 || trig_pos !== 10'd0) begin
      errors++;
      $display("FAIL ramp_fall done=%b rd=%0d trig_pos=%0d expected 1 0 0", g, rd_data, trig_pos);
    end
  endtask
  task automatic test_force_pre0;
    bit g, a;
    int t;
    capture(1, 4095, 1'b0, 0, 1'b1, 1'b0, 3000, g, t, a);
    checks++;
    if (!g || q.size() != DEPTH) begin
      errors++;
      $display("FAIL force_pre0 done=%b samples=%0d expected done=1 samples=1024", g, q.size());
    end
  endtask
  task automatic test_arm_mid_post;
    bit g, a;
    int t;
    capture(0, 2000, 1'b0, 256, 1'b0, 1'b1, 8000, g, t, a);
    checks++;
    if (!g) begin
      errors++;
      $display("FAIL arm_mid_post done=%b expected 1", g);
    end
  endtask
  task automatic test_back_to_back_random;
    bit g, a;
    int t;
    int pls[3];
    pls[0] = int'($urandom_range(2, 1021));
    pls[1] = 1023;
    pls[2] = 1;
    for (int n = 0; n < 3; n++) begin
      capture(1, int'($urandom_range(500, 3500)), 1'($urandom_range(1)), pls[n], 1'b0, 1'b0, 4000, g, t, a);
      checks++;
      if (!g) begin
        errors++;
        $display("FAIL random_capture run=%0d pre_len=%0d done=%b expected 1", n, pls[n], g);
      end
    end
  endtask
  task automatic test_reset_mid;
    bit g, a;
    int t;
    trig_level = 12'd2000;
    trig_edge = 1'b0;
    pre_len = '0;
    arm = 1'b1;
    @(negedge clk_in);
    arm = 1'b0;
    adc_valid = 1'b1;
    adc_data = 12'd10;
    repeat (5) @(negedge clk_in);
    adc_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || trig_pos !== '0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b trig_pos=%0d expected 0 0 0", busy, done, trig_pos);
    end
    capture(3, 2000, 1'b0, 0, 1'b0, 1'b0, 3000, g, t, a);
    checks++;
    if (!g || trig_pos !== 10'd50) begin
      errors++;
      $display("FAIL reset_mid_rearm done=%b trig_pos=%0d expected done=1 trig_pos=50", g, trig_pos);
    end
  endtask
  task automatic test_auto;
    bit g, a;
    int t;
    capture(2, 2000, 1'b0, 16, 1'b0, 1'b0, AUTO_ON ? 3000 : 400, g, t, a);
    checks++;
    if (AUTO_ON ? (!g || trig_auto !== 1'b1 || trig_pos !== 10'd116)
                : (g || done !== 1'b0 || trig_auto !== 1'b0)) begin
      errors++;
      $display("FAIL auto_trigger done=%b trig_auto=%b trig_pos=%0d expected done=%b trig_auto=%b", g, trig_auto, trig_pos, AUTO_ON, AUTO_ON);
    end
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
  endtask
  initial begin
    test_reset;
    test_ramp_rising;
    test_ramp_falling;
    test_force_pre0;
    test_arm_mid_post;
    test_back_to_back_random;
    test_reset_mid;
    test_auto;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_trig_capture.md
ADC_TRIG_CAPTURE -- requirements
Module: adc_trig_capture

Interface
REQ-001 The block SHALL have parameters: DATA_W, default 12, ADC sample width; ADDR_W, default 10, buffer depth 2^ADDR_W; AUTO_TIMEOUT, default 65535, auto-trigger timeout in valid samples.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk_in  in  1  capture clock (ADC user clock domain)
- rst  in  1  synchronous reset, active high
- adc_data  in  DATA_W  unsigned sample from ADC driver
- adc_valid  in  1  sample qualifier
- arm  in  1  single-cycle start-capture pulse
- force_trig  in  1  single-cycle manual trigger
- trig_level  in  DATA_W  trigger threshold
- trig_edge  in  1  0 = rising, 1 = falling
- pre_len  in  ADDR_W  pre-trigger sample count
- rd_addr  in  ADDR_W  logical read index (0 = oldest sample)
- rd_data  out  DATA_W  buffer read data
- busy  out  1  capture in progress
- done  out  1  buffer frozen and readable
- trig_pos  out  ADDR_W  physical address of trigger sample
- trig_auto  out  1  last trigger came from timeout

Function
REQ-003 The FSM SHALL have the states IDLE, PRE, WAIT_TRIG, POST and DONE.
REQ-004 In IDLE or DONE, arm SHALL clear done and trig_auto, zero the write pointer and counters, and enter PRE; if pre_len==0 it SHALL enter WAIT_TRIG directly.
REQ-005 arm SHALL be ignored while busy (PRE, WAIT_TRIG, POST).
REQ-006 Each adc_valid cycle in PRE, WAIT_TRIG or POST SHALL write adc_data at the write pointer, then increment the pointer modulo 2^ADDR_W.
REQ-007 PRE SHALL go to WAIT_TRIG after pre_len valid samples have been written.
REQ-008 Rising trigger SHALL be prev<trig_level and cur>=trig_level; falling trigger SHALL be prev>=trig_level and cur<trig_level; prev and cur are consecutive valid samples.
REQ-009 In WAIT_TRIG, a valid sample meeting REQ-008, or force_trig, SHALL latch trig_pos=the write address of that sample and enter POST.
REQ-010 force_trig without adc_valid SHALL latch the next valid sample as the trigger sample.
REQ-011 POST SHALL count 2^ADDR_W-pre_len valid samples, including the trigger sample, then enter DONE with done=1 and busy=0.
REQ-012 rd_data SHALL equal RAM[(trig_pos-pre_len+rd_addr) mod 2^ADDR_W] with one-cycle latency; reads are valid only when done=1.
REQ-013 The edge detector history SHALL be invalidated on arm, so the first sample after arm never triggers.
REQ-014 Simultaneous arm and force_trig in IDLE SHALL arm only; force_trig SHALL be honoured only in WAIT_TRIG.

Reset
REQ-015 rst SHALL force IDLE, busy=0, done=0, trig_pos=0, trig_auto=0, rd_data=0, the pointer and counters to 0, and discard edge history; RAM contents are not reset.
REQ-016 rst asserted mid-capture SHALL abort the capture; done SHALL remain 0 until a new arm completes.

Configuration
REQ-017 With ADC_TRIG_AUTO_EN defined, AUTO_TIMEOUT valid samples in WAIT_TRIG without a trigger SHALL force a trigger on the next valid sample and set trig_auto=1.
REQ-018 Without ADC_TRIG_AUTO_EN, WAIT_TRIG SHALL wait indefinitely, the timeout counter SHALL not exist, and trig_auto SHALL be tied to 0.

Structure
REQ-019 Package adc_cap_pkg SHALL hold the FSM state enum and the default DATA_W/ADDR_W constants.
REQ-020 The buffer SHALL be a sub-module capture_ram: simple dual-port, one write port and one registered read port, inferring block RAM.

Verification
REQ-021 Ramp 0..4095 with step 1, level 2000, rising, pre_len 256, ADDR_W 10 -> done; rd_addr 256 reads 2000; rd_addr 0 reads 1744.
REQ-022 Same ramp with falling edge and a wrap 4095->0, level 100 -> trigger at sample 0 after the wrap; rd_addr pre_len reads 0.
REQ-023 pre_len 0, force_trig with adc_valid low -> next valid sample is at rd_addr 0; 1024 samples are captured.
REQ-024 arm pulsed mid-POST -> ignored; done asserts at the original count.
REQ-025 rst during WAIT_TRIG, then arm -> clean PRE with done=0; no stale trigger from the pre-reset history.
REQ-026 ADC_TRIG_AUTO_EN defined, constant input 50, AUTO_TIMEOUT 100 -> trigger after 100 WAIT_TRIG samples, trig_auto=1; without the macro, done stays 0.
